// File: rtl/pong_pkg.sv
// Shared Pong definitions: game-state encoding, default geometry and
// paddle-range helpers used by the input, ball and render blocks.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

  localparam int SCREEN_H_DEF = 480;
  localparam int PADDLE_H_DEF = 64;
  localparam int STEP_DEF     = 8;

  function automatic int max_y(input int screen_h, input int paddle_h);
    return screen_h - paddle_h;
  endfunction

  function automatic int center_y(input int screen_h, input int paddle_h);
    return (screen_h - paddle_h) / 2;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button front end: 2-flop synchronizer, stability counter and a
// registered 1-cycle press pulse on the accepted rising level.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1, sync2, level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      // Any cycle where the synchronized level agrees again restarts the count.
      if (sync2 != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
          press <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pong_input_controller.sv
// Encoder/button front end for Pong: clamped paddle positions and the
// idle/serve/play/pause game-flow FSM.
import pong_pkg::*;

module pong_input_controller #(
  parameter int SCREEN_H        = SCREEN_H_DEF,
  parameter int PADDLE_H        = PADDLE_H_DEF,
  parameter int STEP            = STEP_DEF,
  parameter int Y_W             = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           l_up,
  input  logic           l_down,
  input  logic           l_btn,
  input  logic           r_up,
  input  logic           r_down,
  input  logic           r_btn,
  input  logic           point_scored,
  input  logic           game_over,
  output logic [Y_W-1:0] paddle_l_y,
  output logic [Y_W-1:0] paddle_r_y,
  output logic [1:0]     state,
  output logic           serve,
  output logic           paused
);

  localparam int NUM_P = 2;
  localparam logic [Y_W:0]   STEP_X = (Y_W+1)'(STEP);
  localparam logic [Y_W:0]   MAX_X  = (Y_W+1)'(max_y(SCREEN_H, PADDLE_H));
  localparam logic [Y_W-1:0] CENTER = Y_W'(center_y(SCREEN_H, PADDLE_H));

  logic [NUM_P-1:0] up_in, down_in, btn_in;
  logic [NUM_P-1:0] up_q, up_qq, down_q, down_qq;
  logic [NUM_P-1:0] up_edge, down_edge, press;
  logic [Y_W-1:0]   y [NUM_P];
  state_e           st;
  logic             any_press, recenter;

  assign up_in   = {r_up, l_up};
  assign down_in = {r_down, l_down};
  assign btn_in  = {r_btn, l_btn};

  always_ff @(posedge clk) begin
    if (rst) begin
      up_q    <= '0;
      up_qq   <= '0;
      down_q  <= '0;
      down_qq <= '0;
    end else begin
      up_q    <= up_in;
      up_qq   <= up_q;
      down_q  <= down_in;
      down_qq <= down_q;
    end
  end

  assign up_edge   = up_q & ~up_qq;
  assign down_edge = down_q & ~down_qq;
  assign any_press = |press;
  assign recenter  = !game_over &&
                     ((st == ST_PLAY && point_scored) || (st == ST_IDLE && any_press));

  for (genvar p = 0; p < NUM_P; p++) begin : g_player
    logic [Y_W:0] y_ext, y_up, y_dn;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_in[p]),
      .press (press[p])
    );

    // One extra bit keeps the clamps free of wrap-around.
    assign y_ext = {1'b0, y[p]};
    assign y_up  = (y_ext < STEP_X) ? '0 : y_ext - STEP_X;
    assign y_dn  = (y_ext > MAX_X - STEP_X) ? MAX_X : y_ext + STEP_X;

    always_ff @(posedge clk) begin
      if (rst || recenter)
        y[p] <= CENTER;
      else if (st == ST_PLAY && (up_edge[p] ^ down_edge[p]))
        y[p] <= up_edge[p] ? y_up[Y_W-1:0] : y_dn[Y_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= ST_IDLE;
      serve  <= 1'b0;
      paused <= 1'b0;
    end else begin
      serve <= 1'b0;
      if (game_over) begin
        st     <= ST_IDLE;
        paused <= 1'b0;
      end else begin
        case (st)
          ST_IDLE: if (any_press) begin
            st    <= ST_SERVE;
            serve <= 1'b1;
          end
          ST_SERVE: st <= ST_PLAY;
          ST_PLAY: begin
            if (point_scored) begin
              st    <= ST_SERVE;
              serve <= 1'b1;
            end else if (any_press) begin
              st     <= ST_PAUSE;
              paused <= 1'b1;
            end
          end
          ST_PAUSE: if (any_press) begin
            st     <= ST_PLAY;
            paused <= 1'b0;
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

  assign state      = st;
  assign paddle_l_y = y[0];
  assign paddle_r_y = y[1];

endmodule

// File: tb/tb_pong_input_controller.sv
// Self-checking bench for pong_input_controller with a short debounce window.
module tb_pong_input_controller;

  localparam int Y_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic l_up = 0, l_down = 0, l_btn = 0, r_up = 0, r_down = 0, r_btn = 0;
  logic point_scored = 0, game_over = 0;
  logic [Y_W-1:0] paddle_l_y, paddle_r_y;
  logic [1:0] state;
  logic serve, paused;

  int errors = 0;
  int checks = 0;
  int exp_l, exp_r;

  pong_input_controller #(
    .SCREEN_H(480), .PADDLE_H(64), .STEP(8), .Y_W(Y_W), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .l_up(l_up), .l_down(l_down), .l_btn(l_btn),
    .r_up(r_up), .r_down(r_down), .r_btn(r_btn),
    .point_scored(point_scored), .game_over(game_over),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .state(state), .serve(serve), .paused(paused)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit lu, ld, ru, rd;
    int el, er;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Paddle reference: one detent of STEP pixels, clamped to [0, 416].
  function automatic int mv(input int y, input bit u, input bit d);
    if (u && !d) return (y < 8) ? 0 : y - 8;
    if (d && !u) return (y + 8 > 416) ? 416 : y + 8;
    return y;
  endfunction

  task automatic strobe(input bit lu, input bit ld, input bit ru, input bit rd);
    l_up = lu; l_down = ld; r_up = ru; r_down = rd;
    tick();
    l_up = 0; l_down = 0; r_up = 0; r_down = 0;
    repeat (3) tick();
  endtask

  task automatic press_btn(input bit left);
    if (left) l_btn = 1; else r_btn = 1;
    repeat (12) tick();
    l_btn = 0; r_btn = 0;
    repeat (12) tick();
  endtask

  initial begin
    vec_t vt[8];
    int sc, seen;
    bit u, d, ru, rd;

    vt[0] = '{0, 1, 0, 0, 216, 208};
    vt[1] = '{0, 0, 0, 1, 216, 216};
    vt[2] = '{1, 0, 1, 0, 208, 208};
    vt[3] = '{1, 1, 0, 0, 208, 208};
    vt[4] = '{0, 1, 1, 0, 216, 200};
    vt[5] = '{0, 0, 1, 1, 216, 200};
    vt[6] = '{1, 0, 0, 1, 208, 208};
    vt[7] = '{0, 0, 0, 0, 208, 208};

    // Reset state
    repeat (3) tick();
    chk("rst_l_y", paddle_l_y, 208);
    chk("rst_r_y", paddle_r_y, 208);
    chk("rst_state", state, 0);
    chk("rst_serve", serve, 0);
    chk("rst_paused", paused, 0);
    rst = 0;
    sc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (state != 0 || serve != 0) sc++;
    end
    chk("idle_hold", sc, 0);

    // Bouncing button: only the final stable level yields a press
    sc = 0; seen = 0;
    l_btn = 1; repeat (2) tick();
    l_btn = 0; repeat (2) tick();
    l_btn = 1;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) l_btn = 0;
      tick();
      if (serve) sc++;
      if (state == 1) seen++;
    end
    chk("bounce_serve_pulses", sc, 1);
    chk("bounce_serve_cycles", seen, 1);
    chk("bounce_state_play", state, 2);
    exp_l = 208; exp_r = 208;

    // Table-driven paddle vectors
    for (int i = 0; i < 8; i++) begin
      strobe(vt[i].lu, vt[i].ld, vt[i].ru, vt[i].rd);
      chk($sformatf("vec%0d_l", i), paddle_l_y, vt[i].el);
      chk($sformatf("vec%0d_r", i), paddle_r_y, vt[i].er);
    end

    // Saturate down, then up
    for (int i = 0; i < 30; i++) begin
      strobe(0, 1, 0, 0);
      exp_l = mv(exp_l, 0, 1);
      chk($sformatf("down%0d", i), paddle_l_y, exp_l);
    end
    chk("down_sat", paddle_l_y, 416);
    for (int i = 0; i < 60; i++) begin
      strobe(1, 0, 0, 0);
      exp_l = mv(exp_l, 1, 0);
      chk($sformatf("up%0d", i), paddle_l_y, exp_l);
    end
    chk("up_sat", paddle_l_y, 0);
    chk("r_untouched", paddle_r_y, 208);

    // Random strobes against the model
    for (int i = 0; i < 40; i++) begin
      u = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1));
      ru = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1));
      strobe(u, d, ru, rd);
      exp_l = mv(exp_l, u, d);
      exp_r = mv(exp_r, ru, rd);
      chk($sformatf("rnd%0d_l", i), paddle_l_y, exp_l);
      chk($sformatf("rnd%0d_r", i), paddle_r_y, exp_r);
    end

    // Held level moves exactly once
    if (exp_r < 16) begin
      strobe(0, 0, 0, 1); exp_r = mv(exp_r, 0, 1);
      strobe(0, 0, 0, 1); exp_r = mv(exp_r, 0, 1);
    end
    r_up = 1; repeat (20) tick(); r_up = 0; repeat (3) tick();
    exp_r = mv(exp_r, 1, 0);
    chk("held_r_up", paddle_r_y, exp_r);

    // Pause blocks movement, resume keeps positions
    press_btn(0);
    chk("pause_state", state, 3);
    chk("pause_flag", paused, 1);
    for (int i = 0; i < 3; i++) strobe(0, 0, 0, 1);
    chk("pause_no_move_r", paddle_r_y, exp_r);
    press_btn(1);
    chk("resume_state", state, 2);
    chk("resume_flag", paused, 0);
    chk("resume_no_queue_r", paddle_r_y, exp_r);

    // Point scored: recenter and re-serve
    point_scored = 1; tick(); point_scored = 0;
    chk("point_state", state, 1);
    chk("point_serve", serve, 1);
    chk("point_l_y", paddle_l_y, 208);
    chk("point_r_y", paddle_r_y, 208);
    tick();
    chk("point_play", state, 2);
    chk("point_serve_off", serve, 0);

    // Game over from PAUSE
    press_btn(1);
    chk("pause2_state", state, 3);
    game_over = 1; tick(); game_over = 0;
    chk("gameover_state", state, 0);
    chk("gameover_paused", paused, 0);

    // point_scored outside PLAY is ignored
    point_scored = 1; tick(); point_scored = 0; tick();
    chk("idle_point_ignored", state, 0);

    // Reset during SERVE
    l_btn = 1; seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      tick();
      if (state == 1) seen = 1;
    end
    chk("reach_serve", seen, 1);
    rst = 1; l_btn = 0; tick();
    chk("rst_serve_state", state, 0);
    chk("rst_serve_pulse", serve, 0);
    chk("rst_serve_l_y", paddle_l_y, 208);
    chk("rst_serve_r_y", paddle_r_y, 208);
    rst = 0; repeat (14) tick();
    chk("post_rst_idle", state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
